// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op and state encodings,
// divider defaults and the signed-magnitude helper.
package mdu_pkg;

   localparam int          DIV_STEPS_DEF = 32;
   localparam logic [31:0] DIV0_QUOT     = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      MDU_MULT  = 3'd0,
      MDU_MULTU = 3'd1,
      MDU_DIV   = 3'd2,
      MDU_DIVU  = 3'd3,
      MDU_MTHI  = 3'd4,
      MDU_MTLO  = 3'd5
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } mdu_state_e;

   // Magnitude of v when treated as signed (sgn=1), otherwise v unchanged.
   function automatic logic [31:0] abs_val(input logic [31:0] v, input logic sgn);
      return (sgn && v[31]) ? (32'd0 - v) : v;
   endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// Restoring shift-subtract divider core: one quotient bit per cycle on
// unsigned operands, partial remainder in the upper half of a 64-bit register.
module mdu_div_iter
   import mdu_pkg::*;
#(
   parameter int STEPS = DIV_STEPS_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        last_step,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   localparam int CW = $clog2(STEPS + 1);

   logic [63:0]   acc_r;
   logic [31:0]   dsr_r;
   logic [CW-1:0] cnt_r;
   logic          active_r;
   logic [32:0]   diff_s;

   // Shifted partial remainder minus divisor; bit 32 set means the trial borrowed.
   assign diff_s    = acc_r[63:31] - {1'b0, dsr_r};
   assign last_step = active_r && (cnt_r == CW'(STEPS - 1));
   assign quotient  = acc_r[31:0];
   assign remainder = acc_r[63:32];

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_r    <= 64'd0;
         dsr_r    <= 32'd0;
         cnt_r    <= '0;
         active_r <= 1'b0;
      end else if (abort) begin
         cnt_r    <= '0;
         active_r <= 1'b0;
      end else if (start) begin
         acc_r    <= {32'd0, dividend};
         dsr_r    <= divisor;
         cnt_r    <= '0;
         active_r <= 1'b1;
      end else if (active_r) begin
         acc_r    <= diff_s[32] ? {acc_r[62:0], 1'b0}
                                : {diff_s[31:0], acc_r[30:0], 1'b1};
         cnt_r    <= cnt_r + CW'(1);
         active_r <= !last_step;
      end
   end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller owning HI/LO for the execute stage.
// Optional divide early-out is enabled by defining MDU_DIV_EARLY_OUT_EN.
module mdu_ctrl
   import mdu_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int DIV_STEPS = DIV_STEPS_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      req_op,
   input  logic [XLEN-1:0] req_src1,
   input  logic [XLEN-1:0] req_src2,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] hi_rdata,
   output logic [XLEN-1:0] lo_rdata
);

   mdu_state_e  state_r, state_nxt;
   logic        accept_s, is_mul_s, is_div_s, sgn_s, early_s;
   logic [31:0] dvd_mag_s, dsr_mag_s, q_mag_s, r_mag_s, q_fix_s, r_fix_s;
   logic [31:0] div_q_s, div_r_s;
   logic        div_last_s;
   logic [63:0] prod_s;
   logic [32:0] mul_a_r, mul_b_r;
   logic [31:0] hi_r, lo_r, dvd_mag_r;
   logic        q_neg_r, r_neg_r, early_r, done_r;

   assign req_ready = (state_r == ST_IDLE) && !flush;
   assign accept_s  = req_valid && req_ready;
   assign is_mul_s  = accept_s && ((req_op == MDU_MULT) || (req_op == MDU_MULTU));
   assign is_div_s  = accept_s && ((req_op == MDU_DIV)  || (req_op == MDU_DIVU));
   assign sgn_s     = (req_op == MDU_MULT) || (req_op == MDU_DIV);
   assign dvd_mag_s = abs_val(req_src1, sgn_s);
   assign dsr_mag_s = abs_val(req_src2, sgn_s);

`ifdef MDU_DIV_EARLY_OUT_EN
   assign early_s = is_div_s && (dsr_mag_s != 32'd0) && (dsr_mag_s > dvd_mag_s);
`else
   assign early_s = 1'b0;
`endif

   // Low 64 bits of the sign-extended product equal the 66-bit signed product's.
   assign prod_s  = {{31{mul_a_r[32]}}, mul_a_r} * {{31{mul_b_r[32]}}, mul_b_r};
   assign q_mag_s = early_r ? 32'd0 : div_q_s;
   assign r_mag_s = early_r ? dvd_mag_r : div_r_s;
   assign q_fix_s = q_neg_r ? (32'd0 - q_mag_s) : q_mag_s;
   assign r_fix_s = r_neg_r ? (32'd0 - r_mag_s) : r_mag_s;

   assign busy     = (state_r != ST_IDLE);
   assign done     = done_r;
   assign hi_rdata = hi_r;
   assign lo_rdata = lo_r;

   mdu_div_iter #(.STEPS(DIV_STEPS)) u_div (
      .clk       (clk),
      .reset     (reset),
      .start     (is_div_s && !early_s),
      .abort     (flush),
      .dividend  (dvd_mag_s),
      .divisor   (dsr_mag_s),
      .last_step (div_last_s),
      .quotient  (div_q_s),
      .remainder (div_r_s)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_r <= ST_IDLE;
      else       state_r <= state_nxt;
   end

   // Next-state logic; flush returns any in-flight op to IDLE.
   always_comb begin
      state_nxt = state_r;
      case (state_r)
         ST_IDLE: begin
            if (is_mul_s)      state_nxt = ST_MUL;
            else if (is_div_s) state_nxt = early_s ? ST_FIX : ST_DIV;
            else               state_nxt = ST_IDLE;
         end
         ST_MUL:  state_nxt = ST_IDLE;
         ST_DIV: begin
            if (flush)           state_nxt = ST_IDLE;
            else if (div_last_s) state_nxt = ST_FIX;
            else                 state_nxt = ST_DIV;
         end
         ST_FIX:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Operand capture, HI/LO writes and the done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         hi_r      <= 32'd0;
         lo_r      <= 32'd0;
         done_r    <= 1'b0;
         mul_a_r   <= 33'd0;
         mul_b_r   <= 33'd0;
         dvd_mag_r <= 32'd0;
         q_neg_r   <= 1'b0;
         r_neg_r   <= 1'b0;
         early_r   <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (accept_s && (req_op == MDU_MTHI)) begin
            hi_r   <= req_src1;
            done_r <= 1'b1;
         end else if (accept_s && (req_op == MDU_MTLO)) begin
            lo_r   <= req_src1;
            done_r <= 1'b1;
         end else if ((state_r == ST_MUL) && !flush) begin
            hi_r   <= prod_s[63:32];
            lo_r   <= prod_s[31:0];
            done_r <= 1'b1;
         end else if ((state_r == ST_FIX) && !flush) begin
            hi_r   <= r_fix_s;
            lo_r   <= q_fix_s;
            done_r <= 1'b1;
         end
         if (is_mul_s) begin
            mul_a_r <= {sgn_s & req_src1[31], req_src1};
            mul_b_r <= {sgn_s & req_src2[31], req_src2};
         end
         if (is_div_s) begin
            dvd_mag_r <= dvd_mag_s;
            q_neg_r   <= sgn_s & (req_src1[31] ^ req_src2[31]);
            r_neg_r   <= sgn_s & req_src1[31];
            early_r   <= early_s;
         end
      end
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl with a HI/LO scoreboard; divide latency
// expectations follow MDU_DIV_EARLY_OUT_EN when it is defined.
module tb_mdu_ctrl;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        reset, req_valid, req_ready, flush, busy, done;
   logic [2:0]  req_op;
   logic [31:0] req_src1, req_src2, hi_rdata, lo_rdata;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] sb_q[$];

   always #5 clk = ~clk;

   mdu_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_src1  (req_src1),
      .req_src2  (req_src2),
      .flush     (flush),
      .busy      (busy),
      .done      (done),
      .hi_rdata  (hi_rdata),
      .lo_rdata  (lo_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one op for a single accept edge and record its expected HI/LO.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el);
      sb_q.push_back({eh, el});
      req_valid = 1'b1;
      req_op    = op;
      req_src1  = a;
      req_src2  = b;
      tick();
      req_valid = 1'b0;
      req_src1  = $urandom;
      req_src2  = $urandom;
   endtask

   // Called one cycle after accept; waits (bounded) for done and checks the result.
   task automatic expect_done(input string tag, input int lat, input int nbusy);
      int n  = 1;
      int bc = 0;
      int rc = 0;
      logic [63:0] e;
      while ((done !== 1'b1) && (n < lat + 8)) begin
         if (busy === 1'b1) bc++;
         if (req_ready === 1'b1) rc++;
         tick();
         n++;
      end
      chk({tag, "_latency"}, n, lat);
      chk({tag, "_busy_cycles"}, bc, nbusy);
      chk({tag, "_ready_while_busy"}, rc, 0);
      chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      e = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
      chk({tag, "_hi"}, hi_rdata, e[63:32]);
      chk({tag, "_lo"}, lo_rdata, e[31:0]);
   endtask

   task automatic expect_no_done(input string tag, input int ncyc);
      int dn = 0;
      for (int i = 0; i < ncyc; i++) begin
         tick();
         if (done !== 1'b0) dn++;
      end
      chk({tag, "_no_done"}, dn, 0);
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; req_valid = 1'b0;
      req_op = 3'd0; req_src1 = 32'd0; req_src2 = 32'd0;
      repeat (3) tick();
      chk("rst_hi", hi_rdata, 32'd0);
      chk("rst_lo", lo_rdata, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      reset = 1'b0;
      tick();
      chk("rst_ready", {31'd0, req_ready}, 32'd1);

      issue(MDU_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      expect_done("mult", 2, 1);
      issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      expect_done("multu", 2, 1);
      issue(MDU_MTHI, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'h0000_0001);
      expect_done("mthi", 1, 0);
      issue(MDU_MTLO, 32'hCAFE_F00D, 32'd0, 32'h1234_5678, 32'hCAFE_F00D);
      expect_done("mtlo", 1, 0);
      tick();
      chk("mtlo_single_pulse", {31'd0, done}, 32'd0);

      // Signed divide with a request held through the busy window.
      issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      req_valid = 1'b1; req_op = MDU_MTLO; req_src1 = 32'h55AA_55AA;
      expect_done("div_neg7_2", 34, 33);
      sb_q.push_back({32'hFFFF_FFFF, 32'h55AA_55AA});
      tick();
      req_valid = 1'b0;
      expect_done("held_mtlo", 1, 0);

      issue(MDU_DIVU, 32'd100, 32'd0, 32'd100, DIV0_QUOT);
      expect_done("divu_by0", 34, 33);
      issue(MDU_DIV, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'h0000_0001);
      expect_done("div_neg_by0", 34, 33);
      issue(MDU_DIV, 32'd20, 32'hFFFF_FFFD, 32'd2, 32'hFFFF_FFFA);
      expect_done("div_20_neg3", 34, 33);

      // Flush at step 10 of a divide.
      req_valid = 1'b1; req_op = MDU_DIVU; req_src1 = 32'd1000; req_src2 = 32'd7;
      tick();
      req_valid = 1'b0;
      repeat (9) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      chk("flush_busy", {31'd0, busy}, 32'd0);
      chk("flush_done", {31'd0, done}, 32'd0);
      chk("flush_ready", {31'd0, req_ready}, 32'd1);
      expect_no_done("flush", 40);
      chk("flush_hi_kept", hi_rdata, 32'd2);
      chk("flush_lo_kept", lo_rdata, 32'hFFFF_FFFA);
      issue(MDU_DIVU, 32'd1000, 32'd7, 32'd6, 32'd142);
      expect_done("divu_1000_7", 34, 33);

      // Reserved op is ignored.
      req_valid = 1'b1; req_op = 3'd6; req_src1 = 32'hFFFF_0000;
      tick();
      req_valid = 1'b0;
      chk("rsvd_busy", {31'd0, busy}, 32'd0);
      expect_no_done("rsvd", 3);
      chk("rsvd_hi", hi_rdata, 32'd6);
      chk("rsvd_lo", lo_rdata, 32'd142);

      // Flush blocks an MTHI accept.
      flush = 1'b1; req_valid = 1'b1; req_op = MDU_MTHI; req_src1 = 32'hDEAD_BEEF;
      #1;
      chk("flush_mthi_ready", {31'd0, req_ready}, 32'd0);
      tick();
      flush = 1'b0; req_valid = 1'b0;
      chk("flush_mthi_done", {31'd0, done}, 32'd0);
      chk("flush_mthi_hi", hi_rdata, 32'd6);

      // Reset at step 20 of a divide.
      req_valid = 1'b1; req_op = MDU_DIV; req_src1 = 32'd5000; req_src2 = 32'd3;
      tick();
      req_valid = 1'b0;
      repeat (19) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midrst_hi", hi_rdata, 32'd0);
      chk("midrst_lo", lo_rdata, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      expect_no_done("midrst", 40);

`ifdef MDU_DIV_EARLY_OUT_EN
      issue(MDU_DIVU, 32'd3, 32'd10, 32'd3, 32'd0);
      expect_done("divu_3_10", 2, 1);
      issue(MDU_DIVU, 32'd0, 32'd5, 32'd0, 32'd0);
      expect_done("divu_0_5", 2, 1);
`else
      issue(MDU_DIVU, 32'd3, 32'd10, 32'd3, 32'd0);
      expect_done("divu_3_10", 34, 33);
      issue(MDU_DIVU, 32'd0, 32'd5, 32'd0, 32'd0);
      expect_done("divu_0_5", 34, 33);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multiply/divide unit controller for the execute stage.
- Accepts one HI/LO-producing operation at a time from EXE: MULT, MULTU, DIV, DIVU, MTHI or MTLO.
- Sequences a 2-cycle multiply and an iterative 32-step divider, and owns the HI/LO registers.
- Drives a busy/stall signal to the hazard unit and aborts cleanly on an exception flush from WB.

Parameters:
- XLEN, 32, operand width; only 32 is supported.
- DIV_STEPS, 32, divider iterations (one quotient bit per cycle).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  EXE presents a valid MDU op
- req_ready  out  1  controller can accept an op this cycle
- req_op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 reserved, ignored
- req_src1  in  32  rs value (dividend / multiplicand / MTHI-MTLO data)
- req_src2  in  32  rt value (divisor / multiplier)
- flush  in  1  exception/eret flush from WB; kills the in-flight op
- busy  out  1  op in flight; EXE must stall any MFHI/MFLO or new MDU op
- done  out  1  one-cycle pulse; HI/LO hold the new result this cycle
- hi_rdata  out  32  current HI
- lo_rdata  out  32  current LO

Behaviour:
- Reset values:
  - state IDLE; HI = LO = 0.
  - busy = 0, done = 0, req_ready = 1 (the next cycle after reset deasserts, if flush is low).
- Accept rule:
  - req_ready = (state==IDLE) && !flush.
  - An op is accepted at a rising edge where req_valid && req_ready.
  - Operands are latched at that edge; EXE may change them afterwards.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE -> MUL on MULT/MULTU.
  - IDLE -> DIV on DIV/DIVU.
  - MTHI/MTLO stay in IDLE.
  - MUL -> IDLE after 1 cycle.
  - DIV -> FIX after DIV_STEPS cycles.
  - FIX -> IDLE after 1 cycle.
- MTHI/MTLO:
  - HI (or LO) is written at the accept edge.
  - done pulses the following cycle; busy never asserts.
- Multiply:
  - Operands are sign- or zero-extended to 33 bits, and a 66-bit signed product is formed.
  - The product is registered in MUL.
  - HI = prod[63:32], LO = prod[31:0], written at the MUL->IDLE edge.
  - done is high in the next cycle. Total: done 2 cycles after accept.
- Divide:
  - Accept edge: for DIV, magnitudes are latched and the quotient and remainder signs are recorded.
  - DIV state: restoring shift-subtract, one step per cycle via the sub-module.
  - FIX state: sign correction (quotient negated if signs differ; remainder takes the dividend's sign). LO = quotient, HI = remainder, written at the FIX->IDLE edge.
  - done is high 34 cycles after accept.
- Divide by zero is not an exception:
  - LO = 0xFFFFFFFF (before sign fixup for DIV), HI = dividend.
  - Full latency is retained.
- busy is high in MUL, DIV and FIX; it is low in IDLE and in the done cycle.
- flush:
  - In any non-IDLE state: go to IDLE at that edge, leave HI/LO untouched, no done pulse.
  - Simultaneous with req_valid in IDLE: the request is not accepted.
  - Simultaneous with an MTHI/MTLO accept attempt: no write.
  - req_ready = 1 the cycle after flush deasserts.
- Reset mid-operation aborts and clears HI/LO to 0.
- Reserved req_op values are ignored: no state change, no done pulse.

Optional Feature:
- Macro: MDU_DIV_EARLY_OUT_EN.
- Defined:
  - At the accept edge of DIV/DIVU, if |divisor| > |dividend| (magnitudes, divisor ≠ 0), go directly to FIX with quotient 0 and remainder = |dividend|.
  - done then comes 2 cycles after accept.
  - Also when dividend == 0: quotient 0, remainder 0, 2 cycles.
- Undefined: every divide takes the full 34 cycles.

Decomposition:
- Shared package mdu_pkg:
  - op encodings MDU_MULT..MDU_MTLO.
  - state encodings.
  - DIV_STEPS default.
  - constant DIV0_QUOT = 32'hFFFFFFFF.
- One sub-module, mdu_div_iter:
  - holds the 64-bit partial-remainder/quotient register and the step counter.
  - inputs: start, abort, unsigned dividend/divisor.
  - outputs: last_step, quotient, remainder.
- The FSM, sign handling, the multiplier and HI/LO stay in mdu_ctrl.

Test Plan:
- MULT src1=0xFFFFFFFD (−3), src2=5 -> 2 cycles later done=1, hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high exactly 1 cycle.
- MULTU 0xFFFFFFFF×0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; then MTHI 0x12345678 -> hi=0x12345678 next cycle, lo unchanged, busy stays 0.
- DIV −7 (0xFFFFFFF9) / 2 -> done at cycle 34, lo=0xFFFFFFFD, hi=0xFFFFFFFF; req_ready=0 throughout cycles 1–33; a req_valid held during that window is accepted the cycle after done.
- DIVU 100/0 -> done at cycle 34, lo=0xFFFFFFFF, hi=100.
- DIVU 1000/7 with flush pulsed at step 10 -> no done, hi/lo keep prior values, req_ready=1 next cycle; new DIVU 1000/7 -> lo=142, hi=6.
- Reset asserted at step 20 of a DIV -> hi=lo=0, busy=0, done never pulses. With MDU_DIV_EARLY_OUT_EN: DIVU 3/10 -> done at cycle 2, lo=0, hi=3.
